// File: rtl/haz_stall_ctrl_if.sv
// haz_stall_ctrl_if
// Bundles the signals exchanged between the pipeline datapath and the
// hazard/stall controller.
//   ID side  : id_rs, id_rt, id_uses_rs, id_uses_rt, id_mem_write
//   EX side  : ex_dst, ex_reg_write, ex_mem_read, branch_taken
//   control  : hold_req (external freeze)
//   outputs  : pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
//              stall_active, stall_count
// master = pipeline datapath, slave = controller.
interface haz_stall_ctrl_if #(
  parameter int REG_W  = 3,
  parameter int STAT_W = 16
);
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_mem_write;
  logic [REG_W-1:0]  ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              branch_taken;
  logic              hold_req;
  logic              pc_en;
  logic              ifid_en;
  logic              idex_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              stall_active;
  logic [STAT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_mem_write,
           ex_dst, ex_reg_write, ex_mem_read, branch_taken, hold_req,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
           stall_active, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_mem_write,
           ex_dst, ex_reg_write, ex_mem_read, branch_taken, hold_req,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush,
           stall_active, stall_count
  );
endinterface

// File: rtl/haz_stall_ctrl.sv
// haz_stall_ctrl
// Hazard detection and stall controller between ID, EX and MEM.
// Detects load-use and store-data hazards against the EX destination,
// stalls PC/IF-ID for STALL_CYCLES cycles while bubbling ID-EX, flushes
// on a taken branch, freezes everything on hold_req and keeps a
// saturating count of stall cycles.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous reset, active-low
//   bus    - haz_stall_ctrl_if.slave (ID/EX inputs, pipeline controls)
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue; a new hazard stalls this cycle
// STALL | multi-cycle stall in progress, cnt = stall cycles remaining
module haz_stall_ctrl #(
  parameter int REG_W        = 3,
  parameter int STALL_CYCLES = 1,
  parameter int ZERO_SKIP    = 1,
  parameter int FWD_STORE    = 0,
  parameter int STAT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  haz_stall_ctrl_if.slave bus
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0]        CNT_INIT = 4'(STALL_CYCLES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  state_t            state;
  logic [3:0]        cnt;
  logic [STAT_W-1:0] stall_count_q;

  logic ex_dst_live;
  logic match_rs;
  logic match_rt;
  logic load_use;
  logic store_data;
  logic haz;
  logic stall_now;
  logic stall_go;

  // A write to r0 is discarded by the register file, so it is not a
  // producer when ZERO_SKIP is set.
  assign ex_dst_live = bus.ex_reg_write &&
                       !((ZERO_SKIP != 0) && (bus.ex_dst == '0));
  assign match_rs    = ex_dst_live && (bus.id_rs == bus.ex_dst);
  assign match_rt    = ex_dst_live && (bus.id_rt == bus.ex_dst);

  // Qualifiers are ANDed in so unused (possibly X) source fields never
  // produce a hazard.
  assign load_use   = bus.ex_mem_read &&
                      ((bus.id_uses_rs && match_rs) ||
                       ((bus.id_uses_rt || bus.id_mem_write) && match_rt));
  assign store_data = (FWD_STORE == 0) && bus.id_mem_write &&
                      !bus.ex_mem_read && match_rt;
  assign haz        = load_use || store_data;

  // Once in STALL the remaining cycles run out regardless of haz.
  assign stall_now = (state == STALL) || haz;
  assign stall_go  = !bus.hold_req && !bus.branch_taken && stall_now;

  // Outputs are decoded from state and the live inputs so a hazard
  // seen in ID stalls in the very same cycle. Reset forces PASS
  // regardless of inputs.
  always_comb begin
    bus.pc_en        = 1'b1;
    bus.ifid_en      = 1'b1;
    bus.idex_en      = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.stall_active = 1'b0;
    if (rst_n) begin
      if (bus.hold_req) begin
        bus.pc_en   = 1'b0;
        bus.ifid_en = 1'b0;
        bus.idex_en = 1'b0;
      end else if (bus.branch_taken) begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end else if (stall_now) begin
        bus.pc_en        = 1'b0;
        bus.ifid_en      = 1'b0;
        bus.idex_flush   = 1'b1;
        bus.stall_active = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      cnt           <= 4'd0;
      stall_count_q <= '0;
    end else if (!bus.hold_req) begin
      if (bus.branch_taken) begin
        state <= RUN;
        cnt   <= 4'd0;
      end else if (state == STALL) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RUN;
      end else if (haz && (STALL_CYCLES > 1)) begin
        // this cycle already counts as the first stall cycle
        state <= STALL;
        cnt   <= CNT_INIT;
      end
      if (stall_go && (stall_count_q != STAT_MAX))
        stall_count_q <= stall_count_q + STAT_W'(1);
    end
  end

  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_haz_stall_ctrl.sv
module tb_haz_stall_ctrl;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       mw;
    logic [2:0] dst;
    logic       rw;
    logic       mr;
    logic       br;
    logic       hold;
  } stim_t;

  typedef struct {
    logic [5:0] ctl;
    int         count;
  } exp_t;

  // Two configurations driven with identical stimulus.
  // k=0: STALL_CYCLES=3, ZERO_SKIP=1, FWD_STORE=0, STAT_W=4
  // k=1: STALL_CYCLES=1, ZERO_SKIP=0, FWD_STORE=1, STAT_W=16
  int sc[2]      = '{3, 1};
  bit zs[2]      = '{1'b1, 1'b0};
  bit fs[2]      = '{1'b0, 1'b1};
  int stat_max[2] = '{15, 65535};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  haz_stall_ctrl_if #(.REG_W(3), .STAT_W(4))  bus_a ();
  haz_stall_ctrl_if #(.REG_W(3), .STAT_W(16)) bus_b ();

  haz_stall_ctrl #(.REG_W(3), .STALL_CYCLES(3), .ZERO_SKIP(1),
                   .FWD_STORE(0), .STAT_W(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

  haz_stall_ctrl #(.REG_W(3), .STALL_CYCLES(1), .ZERO_SKIP(0),
                   .FWD_STORE(1), .STAT_W(16))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int tests = 0;
  int failed = 0;

  // reference model: remaining stall cycles and statistics per config
  int rem[2];
  int cnt_m[2];
  stim_t prev;
  bit prev_rst = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];

  function automatic bit m_haz(int k, stim_t s);
    bit live, mrs, mrt, lu, sd;
    live = s.rw && !(zs[k] && s.dst == 3'd0);
    mrs  = live && (s.rs == s.dst);
    mrt  = live && (s.rt == s.dst);
    lu   = s.mr && ((s.urs && mrs) || ((s.urt || s.mw) && mrt));
    sd   = !fs[k] && s.mw && !s.mr && mrt;
    return lu || sd;
  endfunction

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, stall_active}
  function automatic logic [5:0] m_out(int k, stim_t s, bit rst);
    if (!rst) return 6'b111000;
    if (s.hold) return 6'b000000;
    if (s.br) return 6'b111110;
    if (rem[k] > 0 || m_haz(k, s)) return 6'b001011;
    return 6'b111000;
  endfunction

  task automatic m_step(int k, stim_t s);
    bit stalled;
    if (s.hold) return;
    stalled = !s.br && (rem[k] > 0 || m_haz(k, s));
    if (s.br) rem[k] = 0;
    else if (rem[k] > 0) rem[k] = rem[k] - 1;
    else if (m_haz(k, s)) rem[k] = sc[k] - 1;
    if (stalled && cnt_m[k] < stat_max[k]) cnt_m[k] = cnt_m[k] + 1;
  endtask

  task automatic apply(stim_t s);
    bus_a.id_rs = s.rs;        bus_b.id_rs = s.rs;
    bus_a.id_rt = s.rt;        bus_b.id_rt = s.rt;
    bus_a.id_uses_rs = s.urs;  bus_b.id_uses_rs = s.urs;
    bus_a.id_uses_rt = s.urt;  bus_b.id_uses_rt = s.urt;
    bus_a.id_mem_write = s.mw; bus_b.id_mem_write = s.mw;
    bus_a.ex_dst = s.dst;      bus_b.ex_dst = s.dst;
    bus_a.ex_reg_write = s.rw; bus_b.ex_reg_write = s.rw;
    bus_a.ex_mem_read = s.mr;  bus_b.ex_mem_read = s.mr;
    bus_a.branch_taken = s.br; bus_b.branch_taken = s.br;
    bus_a.hold_req = s.hold;   bus_b.hold_req = s.hold;
  endtask

  // One clock cycle: advance the model across the edge, then drive the
  // new inputs (and reset level) and push what the DUTs must show.
  task automatic cycle(stim_t s, bit rst);
    exp_t e;
    @(posedge clk);
    if (prev_rst) begin
      m_step(0, prev);
      m_step(1, prev);
    end
    #1;
    apply(s);
    rst_n = rst;
    if (!rst) begin
      rem = '{0, 0};
      cnt_m = '{0, 0};
    end
    e.ctl = m_out(0, s, rst); e.count = cnt_m[0]; q_a.push_back(e);
    e.ctl = m_out(1, s, rst); e.count = cnt_m[1]; q_b.push_back(e);
    prev = s;
    prev_rst = rst;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // monitor: outputs are presented every cycle; sample mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("ctl_a", int'({bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en,
                           bus_a.ifid_flush, bus_a.idex_flush,
                           bus_a.stall_active}), int'(e.ctl));
        chk("count_a", int'(bus_a.stall_count), e.count);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("ctl_b", int'({bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en,
                           bus_b.ifid_flush, bus_b.idex_flush,
                           bus_b.stall_active}), int'(e.ctl));
        chk("count_b", int'(bus_b.stall_count), e.count);
      end
    end
  end

  stim_t idle, lu3, sd5, sd0, lu0;

  initial begin
    idle = '0;
    lu3 = '0; lu3.rs = 3'd3; lu3.urs = 1'b1; lu3.dst = 3'd3; lu3.rw = 1'b1; lu3.mr = 1'b1;
    sd5 = '0; sd5.rt = 3'd5; sd5.mw = 1'b1; sd5.dst = 3'd5; sd5.rw = 1'b1;
    sd0 = sd5; sd0.rt = 3'd0; sd0.dst = 3'd0;
    lu0 = lu3; lu0.rs = 3'd0; lu0.dst = 3'd0;
    prev = '0;
    apply(idle);

    // reset state
    cycle(idle, 1'b0);
    cycle(lu3, 1'b0);
    cycle(idle, 1'b1);

    // load-use single pulse
    cycle(lu3, 1'b1);
    repeat (4) cycle(idle, 1'b1);

    // store-data and r0 destinations
    cycle(sd5, 1'b1);
    repeat (3) cycle(idle, 1'b1);
    cycle(sd0, 1'b1);
    cycle(lu0, 1'b1);
    repeat (3) cycle(idle, 1'b1);

    // branch in the second stall cycle
    cycle(lu3, 1'b1);
    begin stim_t b; b = idle; b.br = 1'b1; cycle(b, 1'b1); end
    repeat (2) cycle(idle, 1'b1);

    // freeze for two cycles mid-stall
    cycle(lu3, 1'b1);
    begin stim_t h; h = idle; h.hold = 1'b1; cycle(h, 1'b1); cycle(h, 1'b1); end
    repeat (3) cycle(idle, 1'b1);

    // async reset during a stall
    cycle(lu3, 1'b1);
    cycle(idle, 1'b1);
    cycle(idle, 1'b0);
    cycle(idle, 1'b1);
    cycle(idle, 1'b1);

    // persistent hazard: saturation of the narrow counter
    repeat (20) cycle(lu3, 1'b1);
    repeat (3) cycle(idle, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rs   = 3'($urandom_range(0, 7));
      s.rt   = 3'($urandom_range(0, 7));
      s.dst  = ($urandom_range(0, 2) == 0) ? s.rs : 3'($urandom_range(0, 7));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.mw   = 1'($urandom_range(0, 1));
      s.rw   = ($urandom_range(0, 3) != 0);
      s.mr   = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 7) == 0);
      s.hold = ($urandom_range(0, 7) == 0);
      cycle(s, ($urandom_range(0, 199) != 0));
    end

    cycle(idle, 1'b1);
    repeat (2) @(posedge clk);
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/haz_stall_ctrl.md
Name: haz_stall_ctrl

Overview:
- Parametrised hazard detection and stall controller for the pipelined MIPS core.
- Sits between ID, EX and MEM. Compares ID source registers against in-flight destinations and detects load-use and store-data hazards.
- Holds PC/IF-ID for a programmable number of cycles while inserting ID-EX bubbles. Flushes IF-ID/ID-EX on a taken branch.
- Adds a sequential stall counter, external freeze, branch-priority flush and a saturating stall-statistics counter.

Parameters:
- REG_W, 3, register-address width (default matches the 8-entry register file).
- STALL_CYCLES, 1, stall length per detected hazard; legal 1..15.
- ZERO_SKIP, 1, when 1 a destination of register 0 never causes a hazard.
- FWD_STORE, 0, when 1 the store-data hazard against a non-load EX producer is forwarded, so no stall.
- STAT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- id_rs  in  REG_W  ID source register rs.
- id_rt  in  REG_W  ID source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt as an ALU operand.
- id_mem_write  in  1  ID instruction is a store; rt is the store data.
- ex_dst  in  REG_W  EX destination register.
- ex_reg_write  in  1  EX instruction writes ex_dst.
- ex_mem_read  in  1  EX instruction is a load.
- branch_taken  in  1  branch resolved taken in EX this cycle.
- hold_req  in  1  external freeze request (memory wait).
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_flush  out  1  clear ID/EX to NOP (bubble).
- stall_active  out  1  controller is stalling this cycle.
- stall_count  out  STAT_W  total stall cycles since reset; saturates.

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock.
- While rst_n=0:
  - state=RUN, cnt=0, stall_count=0.
  - pc_en=ifid_en=idex_en=1; ifid_flush=idex_flush=stall_active=0.
- Match definition: `m(r) = (r==ex_dst) && ex_reg_write && !(ZERO_SKIP && ex_dst==0)`.
- Load-use hazard: `lu = ex_mem_read && ((id_uses_rs && m(id_rs)) || ((id_uses_rt || id_mem_write) && m(id_rt)))`.
- Store-data hazard: `sd = !FWD_STORE && id_mem_write && !ex_mem_read && m(id_rt)`.
- `haz = lu || sd`.
- Output sets (combinational from state and inputs):
  - STALL: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, stall_active=1.
  - FLUSH: all enables 1, ifid_flush=1, idex_flush=1.
  - PASS: all enables 1, flushes 0.
  - FREEZE: all enables 0, flushes 0, stall_active=0.
- Priority, highest first: hold_req > branch_taken > stall state/haz > pass.
- State RUN:
  - hold_req: FREEZE; state, cnt and stall_count unchanged.
  - branch_taken: FLUSH; stay RUN.
  - haz: STALL; stall_count+1.
    - STALL_CYCLES=1: stay RUN.
    - Otherwise: cnt<=STALL_CYCLES-1, go STALL.
  - Otherwise: PASS.
- State STALL:
  - hold_req: FREEZE; state and cnt held.
  - branch_taken: FLUSH; abort stall, cnt<=0, go RUN.
  - Otherwise: STALL outputs regardless of haz; stall_count+1; cnt<=cnt-1; cnt==1 goes to RUN.
- Re-detection: on return to RUN, haz is re-evaluated the same cycle, so a persisting hazard stalls again immediately.
- stall_count:
  - Increments only in cycles with stall_active=1.
  - Holds at 2^STAT_W-1.
  - Never wraps.
- Reset asserted mid-stall: immediate return to RUN/PASS outputs; cnt and stall_count cleared.
- No X propagation: comparisons on unused sources are masked by the id_uses_* and id_mem_write qualifiers.

Test Plan:
1. Load-use, STALL_CYCLES=1: ex_mem_read=1, ex_reg_write=1, ex_dst=3, id_rs=3, id_uses_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count=1; next cycle PASS once the EX inputs clear.
2. STALL_CYCLES=3, single load-use pulse -> exactly 3 consecutive stall cycles; stall_count=3; then pc_en=1.
3. Store-data: id_mem_write=1, id_rt=5, ex_dst=5, ex_reg_write=1, ex_mem_read=0 -> 1-cycle stall with FWD_STORE=0; no stall with FWD_STORE=1. ex_dst=0 with ZERO_SKIP=1 -> no stall.
4. Branch priority: STALL_CYCLES=3, branch_taken=1 in second stall cycle -> that cycle ifid_flush=idex_flush=1 with all enables 1; next cycle RUN/PASS.
5. Freeze: hold_req=1 for 2 cycles mid-stall (cnt=2) -> all enables 0, cnt and stall_count frozen; after release, the remaining 2 stall cycles occur.
6. Async reset: drop rst_n between clock edges during STALL -> outputs return to PASS immediately and stall_count=0; STAT_W=4 saturation check: 20 stall cycles -> stall_count=15.
